// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if
//   Bundles every signal between the two requesters, the arbiter and the
//   single-port data_memory.
//   slave  : arbiter side. It receives requests and mem_read_data. It drives
//            the ready, response and memory-control signals.
//   master : environment side. This is the requesters plus the memory model.
//   Port 0 : CPU load/store unit.
//   Port 1 : peripheral/DMA reader.
//   req*    : valid/ready handshake plus we, word address and write data.
//   rsp*    : one-cycle completion pulse plus read data and range error.
//   mem_*   : data_memory write_en/addr/write_data, and combinational read_data.
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_write_en, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_write_en, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Two-port arbiter and sequencer in front of the single-port data_memory.
//   It handles one transaction at a time in three phases:
//     IDLE   -> grant a request (combinational ready)
//     ACCESS -> drive the memory
//     RESP   -> one-cycle response
//   An accept in cycle T gives a memory access in T+1 and rspN_valid in T+2.
//   The next accept can happen in T+3 at the earliest.
//   Addresses >= MEM_DEPTH are out of range:
//     - writes to them never reach the memory;
//     - reads of them return 0;
//     - both report rspN_err.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : data_memory_arbiter_if.slave (requests, responses, memory control)
// Configuration
//   ARB_FIXED_PRIO_EN : when defined, port 0 always wins a tie and there is no
//                       round-robin pointer (port 1 can starve). When
//                       undefined, ties alternate round-robin starting at port 0.
module data_memory_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input logic                  clk,
  input logic                  rst,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // One extra bit so that MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  state_t            state;
  logic              lat_we;
  logic              lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              mem_we_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              grant_en;
  logic              pick1;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              lat_in_range;

`ifdef ARB_FIXED_PRIO_EN
  assign pick1 = bus.req1_valid && !bus.req0_valid;
`else
  // ptr names the preferred port on a tie.
  logic ptr;
  assign pick1 = bus.req1_valid && (!bus.req0_valid || ptr);
`endif

  // Ready is gated by rst so that no grant is visible while reset is held.
  assign grant_en = rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = grant_en && !pick1;
  assign bus.req1_ready = grant_en &&  pick1;

  assign win_we    = pick1 ? bus.req1_we    : bus.req0_we;
  assign win_addr  = pick1 ? bus.req1_addr  : bus.req0_addr;
  assign win_wdata = pick1 ? bus.req1_wdata : bus.req0_wdata;

  assign lat_in_range = addr_in_range(lat_addr);

  // Address and write data come straight from the request latches.
  // They therefore hold their last values outside ACCESS.
  // The write enable is registered at grant time. Because it is a flop, an
  // asynchronous reset during ACCESS clears it before the write edge.
  assign bus.mem_addr       = lat_addr;
  assign bus.mem_write_data = lat_wdata;
  assign bus.mem_write_en   = mem_we_q;

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_rdata = rsp_rdata_q;
  assign bus.rsp1_rdata = rsp_rdata_q;
  assign bus.rsp0_err   = rsp_err_q;
  assign bus.rsp1_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_idx      <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      mem_we_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            lat_we    <= win_we;
            lat_idx   <= pick1;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            mem_we_q  <= win_we && addr_in_range(win_addr);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q     <= 1'b0;
          rsp_err_q    <= !lat_in_range;
          rsp_rdata_q  <= (lat_we || !lat_in_range) ? '0 : bus.mem_read_data;
          rsp0_valid_q <= !lat_idx;
          rsp1_valid_q <=  lat_idx;
          state        <= RESP;
        end
        RESP: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          ptr          <= !lat_idx;
`endif
          state        <= IDLE;
        end
        default: begin
          mem_we_q     <= 1'b0;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
`timescale 1ns/1ps
module tb_data_memory_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: combinational read, write on the rising edge.
  // Out-of-range reads return a poison pattern that the arbiter must mask.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  assign bus.mem_read_data = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[9:0]] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (bus.mem_write_en && bus.mem_addr < 32'(DEPTH))
      mem[bus.mem_addr[9:0]] <= bus.mem_write_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];

  // Reference state: which port is preferred, and when the arbiter is free.
  int            pref      = 0;
  int            next_free = 0;
  int            wexp_cyc  = -1;
  logic          wexp_we   = 1'b0;
  logic [AW-1:0] wexp_addr = '0;
  logic [DW-1:0] wexp_data = '0;
  int            resp_cyc  = -1;
  int            resp_port = 0;

  int dut_grants[$];
  int dut_acc[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_port(input int p, input logic v, input logic [DW-1:0] d, input logic e);
    rsp_t r;
    bit   have;
    have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) r = (p == 0) ? q0[0] : q1[0];
    if (v) begin
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL rsp%0d_unexpected: got valid=1 expected no response (cycle %0d)", p, cyc);
      end else begin
        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("rsp%0d_rdata", p), d, r.rdata);
        chk($sformatf("rsp%0d_err", p), e, r.err);
        chk($sformatf("rsp%0d_latency", p), cyc, r.due);
      end
    end else if (have && r.due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp%0d_missing: got no valid expected response due at cycle %0d (cycle %0d)", p, r.due, cyc);
      if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  // Monitor: samples on the falling edge, predicts, and checks.
  initial begin
    logic          v0, v1, we, exp_we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rsp_t          r;
    int            win;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pref      = 0;
        next_free = 0;
        wexp_cyc  = -1;
        resp_cyc  = -1;
        q0.delete();
        q1.delete();
        chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
        chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("rst_mem_we", bus.mem_write_en, 0);
      end else begin
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        win = -1;
        if (cyc >= next_free && (v0 || v1)) begin
`ifdef ARB_FIXED_PRIO_EN
          win = v0 ? 0 : 1;
`else
          win = (v0 && v1) ? pref : (v0 ? 0 : 1);
`endif
        end
        if (bus.req0_ready && v0) begin dut_grants.push_back(0); dut_acc[0] = cyc; end
        if (bus.req1_ready && v1) begin dut_grants.push_back(1); dut_acc[1] = cyc; end
        chk("req0_ready", bus.req0_ready, win == 0);
        chk("req1_ready", bus.req1_ready, win == 1);
        if (win >= 0) begin
          we = (win == 1) ? bus.req1_we    : bus.req0_we;
          a  = (win == 1) ? bus.req1_addr  : bus.req0_addr;
          d  = (win == 1) ? bus.req1_wdata : bus.req0_wdata;
          r.err   = (a >= 32'(DEPTH));
          r.rdata = (we || r.err) ? '0 : ref_mem[a[9:0]];
          r.due   = cyc + 2;
          if (win == 0) q0.push_back(r); else q1.push_back(r);
          wexp_cyc  = cyc + 1;
          wexp_we   = we && !r.err;
          wexp_addr = a;
          wexp_data = d;
          resp_cyc  = cyc + 2;
          resp_port = win;
          next_free = cyc + 3;
        end
        exp_we = (cyc == wexp_cyc) && wexp_we;
        chk("mem_write_en", bus.mem_write_en, exp_we);
        if (cyc == wexp_cyc) begin
          chk("mem_addr", bus.mem_addr, wexp_addr);
          chk("mem_write_data", bus.mem_write_data, wexp_data);
          if (wexp_we) ref_mem[wexp_addr[9:0]] = wexp_data;
        end
        check_port(0, bus.rsp0_valid, bus.rsp0_rdata, bus.rsp0_err);
        check_port(1, bus.rsp1_valid, bus.rsp1_rdata, bus.rsp1_err);
`ifndef ARB_FIXED_PRIO_EN
        if (cyc == resp_cyc) pref = 1 - resp_port;
`endif
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  // Holds a request until it is accepted, then drops valid just after the edge.
  task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 0;
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? (bus.req0_ready === 1'b1) : (bus.req1_ready === 1'b1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_timeout port%0d: got no ready in 30 cycles expected ready", p);
    end
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic random_port(input int p, input int n);
    int            gap;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'(1020 + $urandom_range(0, 7)) : 32'($urandom_range(0, 15));
      d  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        // A brief valid that may be withdrawn before it is granted.
        drive(p, 1'b1, we, a, d);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
      end else begin
        issue(p, we, a, d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int            base;
    int            exp_first;
    logic [DW-1:0] orig9;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h33; ref_mem[3] = 32'h33;
    mem[7] = 32'h77; ref_mem[7] = 32'h77;
    orig9 = mem[9];
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Idle after reset: every output at its reset value.
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", {bus.req1_ready, bus.req0_ready}, 0);
      chk("idle_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
      chk("idle_rdata", {bus.rsp1_rdata, bus.rsp0_rdata}, 0);
      chk("idle_err", {bus.rsp1_err, bus.rsp0_err}, 0);
      chk("idle_mem_we", bus.mem_write_en, 0);
      chk("idle_mem_addr", bus.mem_addr, 0);
      chk("idle_mem_wdata", bus.mem_write_data, 0);
    end
    @(posedge clk); #1;

    // Write then read back on port 0.
    issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'd5, 32'h0);
    idle_cycles(3);
    chk("mem5_written", mem[5], 32'hDEAD_BEEF);

    // Both ports stream reads: grants alternate (or all go to port 0 first).
    exp_first = pref;
    base = dut_grants.size();
    fork
      begin repeat (4) issue(0, 1'b0, 32'd3, 32'h0); end
      begin repeat (4) issue(1, 1'b0, 32'd7, 32'h0); end
    join
    idle_cycles(3);
    chk("stream_grant_count", dut_grants.size() - base, 8);
    if (dut_grants.size() - base >= 8) begin
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) chk("fixed_grant", dut_grants[base + i], 0);
`else
      chk("rr_first_grant", dut_grants[base], exp_first);
      for (int i = 1; i < 8; i++) chk("rr_alternate", dut_grants[base + i], 1 - dut_grants[base + i - 1]);
`endif
    end

    // Out-of-range accesses and the last in-range word.
    issue(1, 1'b1, 32'd1024, 32'h1234);
    issue(1, 1'b0, 32'd1024, 32'h0);
    issue(1, 1'b0, 32'd1023, 32'h0);
    idle_cycles(3);

    // Reset during ACCESS drops the write and restarts arbitration at port 0.
    issue(0, 1'b0, 32'd3, 32'h0);
    idle_cycles(2);
    issue(0, 1'b1, 32'd9, 32'hCAFE_F00D);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("mem9_unchanged", mem[9], orig9);
    base = dut_grants.size();
    fork
      issue(0, 1'b0, 32'd7, 32'h0);
      issue(1, 1'b0, 32'd3, 32'h0);
    join
    chk("post_reset_grant_count", dut_grants.size() - base >= 1, 1);
    if (dut_grants.size() > base) chk("post_reset_first_grant", dut_grants[base], 0);
    issue(0, 1'b0, 32'd9, 32'h0);
    idle_cycles(3);

    // Port 0 raises valid during port 1's response cycle.
    issue(1, 1'b0, 32'd7, 32'h0);
    @(posedge clk); #1;
    issue(0, 1'b0, 32'd3, 32'h0);
    chk("late_raise_gap", dut_acc[0] - dut_acc[1], 3);
    idle_cycles(3);

    // Random traffic from both ports.
    fork
      random_port(0, 40);
      random_port(1, 40);
    join
    idle_cycles(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and sequencer in front of the single-port `data_memory`. It accepts word-access requests from two requesters (port 0: CPU load/store unit, port 1: peripheral/DMA reader). It serialises the winning request onto the memory's `write_en`/`addr`/`write_data` inputs and samples `read_data`. It returns a one-cycle response to the winner and owns every memory control signal, so no requester drives the memory directly.

## Interface
- `ADDR_W`, default 32: width of request and memory address.
- `DATA_W`, default 32: data word width.
- `MEM_DEPTH`, default 1024: number of valid words. Addresses at or above this value are out of range.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request pending on port 0 / port 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle; accepted when valid and ready are both high.
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read.
- `req0_addr` / `req1_addr`  in  ADDR_W  word address.
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data.
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle completion pulse.
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_W  read data. Valid only with `rspN_valid`.
- `rsp0_err` / `rsp1_err`  out  1  out-of-range address. Valid only with `rspN_valid`.
- `mem_write_en`  out  1  to `data_memory.write_en`.
- `mem_addr`  out  ADDR_W  to `data_memory.addr`.
- `mem_write_data`  out  DATA_W  to `data_memory.write_data`.
- `mem_read_data`  in  DATA_W  from `data_memory.read_data`. This path is combinational.

## Operation
- FSM states: IDLE, ACCESS, RESP. Only one transaction is in flight at a time.
- **IDLE**
  - If no valid is asserted, stay in IDLE.
  - Otherwise pick a winner and assert only that port's `reqN_ready`, combinationally.
  - On the clock edge, latch the winner's we, addr and wdata plus the winner index, then go to ACCESS.
- **ACCESS**
  - Drive `mem_addr` from the latched address.
  - `mem_write_en` = latched we AND address in range.
  - `mem_write_data` = latched wdata.
  - On the edge, capture `mem_read_data` into the response register, then go to RESP.
  - Response data: for a write, capture 0. For an out-of-range read, capture 0.
- **RESP**
  - Assert the winner's `rspN_valid` together with `rspN_rdata` and `rspN_err`.
  - Update the round-robin pointer to favour the other port, then go to IDLE.
- Round-robin:
  - The pointer names the preferred port and resets to port 0.
  - With one valid, that port wins.
  - With both valid, the preferred port wins.
- Outside ACCESS: `mem_write_en` = 0, and `mem_addr`/`mem_write_data` hold their last latched values.
- Requesters hold valid and all request fields stable until ready. Dropping valid before ready is allowed; the request is then simply not serviced.
- Outputs never see X. All registers reset to 0.

## Timing
- Reset values:
  - FSM = IDLE, pointer = 0.
  - All `reqN_ready` and `rspN_valid` = 0; `mem_write_en` = 0.
  - `mem_addr`, `mem_write_data`, `rspN_rdata`, `rspN_err` = 0.
- Accept in cycle T (valid & ready) → memory access in T+1 → `rspN_valid` high in T+2 only.
- The write takes effect in memory at the rising edge ending T+1.
- Throughput: at most one transaction every 3 cycles. Next accept is earliest at T+3.
- `reqN_ready` is never high outside IDLE and is never high on both ports in the same cycle.
- Reset asserted mid-transaction: the transaction is dropped with no response.
  - A write is suppressed if reset arrives before the ACCESS edge.
  - Arbitration restarts from IDLE with pointer = 0.
- A requester may raise a new valid in the same cycle its `rspN_valid` is high. It is considered in the following IDLE cycle.

## Configuration
- `ARB_FIXED_PRIO_EN`
  - Defined: port 0 always wins when both ports are valid, and the pointer logic is removed. Port 1 can starve.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `mem_write_en` never 1.
- Port 0 writes 0xDEADBEEF @ 5, then reads @ 5 → first: ready at T, `mem_write_en`=1 only in T+1, `rsp0_valid` in T+2 with rdata 0; second: `rsp0_rdata`=0xDEADBEEF.
- Both ports read continuously at addresses 3 and 7 (preloaded 0x33, 0x77) → grants alternate 0,1,0,1; each response carries the correct data; one response every 3 cycles. With `ARB_FIXED_PRIO_EN`: all grants go to port 0.
- Port 1 writes 0x1234 @ 1024 → `rsp1_err`=1, `rsp1_rdata`=0, `mem_write_en` stays 0; a read @ 1024 also returns err=1.
- Port 0 write accepted, `rst` driven low during ACCESS before the edge → no `rsp0_valid`; memory word unchanged; next grant after reset goes to port 0.
- Port 1 valid only; port 0 raises valid during port 1's RESP cycle → port 0 granted in the next IDLE cycle.
